uart_cmd_decoder: RTL and testbench

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/uart_cmd_decoder.sv | 134 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Byte-stream command decoder: parses cmd/addr/4-byte-data frames from a UART
// receiver into register write/read strobes and streams read data back out.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT   = 17360,
  parameter logic [7:0]  WRITE_CMD = 8'hAA,
  parameter logic [7:0]  READ_CMD  = 8'h00
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_reg_addr,
  output logic [31:0] o_reg_wdata,
  output logic        o_reg_we,
  output logic        o_reg_re,
  input  logic [31:0] i_reg_rdata,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_we,
  input  logic        i_tx_full,
  output logic        o_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_EXEC, S_RDWAIT, S_RESP
  } state_t;

  state_t        state, state_nxt;
  logic          is_read;
  logic [1:0]    cnt;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   resp;
  logic          err_nxt;
  logic          in_frame;
  logic          tmo_hit;

  assign in_frame  = (state == S_ADDR) || (state == S_DATA);
  // A byte landing on the expiry cycle wins over the timeout.
  assign tmo_hit   = in_frame && !i_rx_valid && (tmo_cnt == TW'(TIMEOUT - 1));
  assign o_tx_data = resp[{cnt, 3'b000} +: 8];

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    o_reg_we  = 1'b0;
    o_reg_re  = 1'b0;
    o_tx_we   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == WRITE_CMD || i_rx_data == READ_CMD) state_nxt = S_ADDR;
          else err_nxt = 1'b1;
        end
      end
      S_ADDR: begin
        if (i_rx_valid) state_nxt = S_DATA;
        else if (tmo_hit) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_DATA: begin
        if (i_rx_valid) begin
          if (cnt == 2'd3) state_nxt = S_EXEC;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_EXEC: begin
        err_nxt = i_rx_valid;
        if (is_read) begin
          o_reg_re  = 1'b1;
          state_nxt = S_RDWAIT;
        end else begin
          o_reg_we  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_RDWAIT: begin
        err_nxt   = i_rx_valid;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        err_nxt = i_rx_valid;
        o_tx_we = !i_tx_full;
        if (!i_tx_full && cnt == 2'd3) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      is_read     <= 1'b0;
      cnt         <= 2'd0;
      tmo_cnt     <= '0;
      resp        <= '0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
      o_err       <= 1'b0;
    end else begin
      state <= state_nxt;
      o_err <= err_nxt;
      if (i_rx_valid || !in_frame) tmo_cnt <= '0;
      else                         tmo_cnt <= tmo_cnt + TW'(1);
      case (state)
        S_IDLE:   if (i_rx_valid) is_read <= (i_rx_data == READ_CMD);
        S_ADDR: begin
          if (i_rx_valid) begin
            o_reg_addr <= i_rx_data;
            cnt        <= 2'd0;
          end
        end
        S_DATA: begin
          // cnt wraps 3->0 here, so RESP starts from byte 0.
          if (i_rx_valid) begin
            o_reg_wdata[{cnt, 3'b000} +: 8] <= i_rx_data;
            cnt <= cnt + 2'd1;
          end
        end
        S_RDWAIT: begin
          resp <= i_reg_rdata;
          cnt  <= 2'd0;
        end
        S_RESP:   if (!i_tx_full) cnt <= cnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized and directed bench for uart_cmd_decoder with a frame-level
// scoreboard and a register slave that returns a fixed per-address table.
module tb_uart_cmd_decoder;
  localparam int TMO = 40;
  localparam logic [7:0] WR = 8'hAA;
  localparam logic [7:0] RD = 8'h00;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_reg_addr;
  logic [31:0] o_reg_wdata;
  logic        o_reg_we, o_reg_re;
  logic [31:0] i_reg_rdata;
  logic [7:0]  o_tx_data;
  logic        o_tx_we;
  logic        i_tx_full;
  logic        o_err;

  int vectors = 0, miscompares = 0;
  int cyc = 0, last_cyc = 0, we_cyc = 0;
  int err_cnt = 0, full_viol = 0;
  logic [39:0] wq[$];
  logic [7:0]  rq[$];
  logic [7:0]  tq[$];
  int          tcq[$];
  logic [31:0] rmem [256];

  uart_cmd_decoder #(.TIMEOUT(TMO), .WRITE_CMD(WR), .READ_CMD(RD)) dut (
    .clk(clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_reg_addr(o_reg_addr), .o_reg_wdata(o_reg_wdata), .o_reg_we(o_reg_we),
    .o_reg_re(o_reg_re), .i_reg_rdata(i_reg_rdata), .o_tx_data(o_tx_data),
    .o_tx_we(o_tx_we), .i_tx_full(i_tx_full), .o_err(o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Read data is only meaningful the cycle after o_reg_re; noise otherwise.
  always @(posedge clk) i_reg_rdata <= (o_reg_re === 1'b1) ? rmem[o_reg_addr] : $urandom;

  always @(negedge clk) begin
    if (o_reg_we === 1'b1) begin
      wq.push_back({o_reg_addr, o_reg_wdata});
      we_cyc <= cyc;
    end
    if (o_reg_re === 1'b1) rq.push_back(o_reg_addr);
    if (o_tx_we === 1'b1) begin
      tq.push_back(o_tx_data);
      tcq.push_back(cyc);
      if (i_tx_full) full_viol <= full_viol + 1;
    end
    if (o_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b; i_rx_valid = 1'b1; last_cyc = cyc;
    @(posedge clk); #1;
    i_rx_valid = 1'b0; i_rx_data = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d,
                            input int gap_max);
    logic [7:0] b [6];
    b = '{c, a, d[7:0], d[15:8], d[23:16], d[31:24]};
    for (int i = 0; i < 6; i++) begin
      send_byte(b[i]);
      if (i < 5) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_tx_full = 1'b0;
    idle(3);
    vectors++;
    if ({o_reg_we, o_reg_re, o_tx_we, o_err} !== 4'b0) begin
      miscompares++; $display("FAIL reset_strobes: got %b, want 0000", {o_reg_we, o_reg_re, o_tx_we, o_err});
    end
    vectors++;
    if ({o_reg_addr, o_reg_wdata, o_tx_data} !== 48'h0) begin
      miscompares++; $display("FAIL reset_data: got addr %h wdata %h tx %h, want 0", o_reg_addr, o_reg_wdata, o_tx_data);
    end
    i_reset = 1'b0;
    idle(2);
  endtask

  task automatic test_write;
    int w0 = wq.size(), t0 = tq.size(), e0 = err_cnt;
    send_frame(WR, 8'h12, 32'h12345678, 0);
    idle(4);
    vectors++;
    if (wq.size() != w0 + 1) begin
      miscompares++; $display("FAIL write_count: got %0d, want 1", wq.size() - w0);
    end else begin
      vectors++;
      if (wq[w0] !== {8'h12, 32'h12345678}) begin
        miscompares++; $display("FAIL write_value: got %h, want 1212345678", wq[w0]);
      end
      vectors++;
      if (we_cyc != last_cyc + 1) begin
        miscompares++; $display("FAIL write_latency: got %0d, want 1", we_cyc - last_cyc);
      end
    end
    vectors++;
    if (tq.size() != t0 || err_cnt != e0) begin
      miscompares++; $display("FAIL write_side: got tx %0d err %0d, want 0 0", tq.size() - t0, err_cnt - e0);
    end
    vectors++;
    if (o_reg_addr !== 8'h12 || o_reg_wdata !== 32'h12345678) begin
      miscompares++; $display("FAIL write_hold: got %h %h, want 12 12345678", o_reg_addr, o_reg_wdata);
    end
  endtask

  task automatic test_read;
    int r0 = rq.size(), t0 = tq.size(), e0 = err_cnt;
    logic [31:0] exp;
    exp = rmem[8'h12];
    send_frame(RD, 8'h12, $urandom, 0);
    idle(8);
    vectors++;
    if (rq.size() != r0 + 1 || rq[r0] !== 8'h12) begin
      miscompares++; $display("FAIL read_strobe: got %0d strobes, want 1 at addr 12", rq.size() - r0);
    end
    vectors++;
    if (tq.size() != t0 + 4) begin
      miscompares++; $display("FAIL read_tx_count: got %0d, want 4", tq.size() - t0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (tq[t0 + i] !== exp[8*i +: 8]) begin
          miscompares++; $display("FAIL read_tx_byte%0d: got %h, want %h", i, tq[t0 + i], exp[8*i +: 8]);
        end
      end
      vectors++;
      if (tcq[t0] != last_cyc + 3) begin
        miscompares++; $display("FAIL read_latency: got %0d, want 3", tcq[t0] - last_cyc);
      end
    end
    vectors++;
    if (err_cnt != e0) begin
      miscompares++; $display("FAIL read_err: got %0d, want 0", err_cnt - e0);
    end
  endtask

  task automatic test_tx_full;
    int t0 = tq.size(), e0 = err_cnt, fv0 = full_viol;
    logic [31:0] exp;
    exp = rmem[8'h12];
    send_frame(RD, 8'h12, $urandom, 1);
    for (int k = 0; k < 20 && tq.size() < t0 + 2; k++) idle(1);
    vectors++;
    if (tq.size() < t0 + 2) begin
      miscompares++; $display("FAIL full_wait: got %0d bytes, want 2 within 20 cycles", tq.size() - t0);
    end
    i_tx_full = 1'b1;
    send_byte(WR);  // dropped: decoder is busy responding
    idle(4);
    vectors++;
    if (tq.size() != t0 + 2 || full_viol != fv0) begin
      miscompares++; $display("FAIL full_stall: got %0d bytes %0d viol, want 2 0", tq.size() - t0, full_viol - fv0);
    end
    i_tx_full = 1'b0;
    idle(6);
    vectors++;
    if (tq.size() != t0 + 4) begin
      miscompares++; $display("FAIL full_count: got %0d, want 4", tq.size() - t0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (tq[t0 + i] !== exp[8*i +: 8]) begin
          miscompares++; $display("FAIL full_byte%0d: got %h, want %h", i, tq[t0 + i], exp[8*i +: 8]);
        end
      end
    end
    vectors++;
    if (err_cnt != e0 + 1) begin
      miscompares++; $display("FAIL drop_err: got %0d, want 1", err_cnt - e0);
    end
  endtask

  task automatic test_timeout;
    int w0 = wq.size(), e0 = err_cnt;
    send_byte(WR); send_byte(8'h12); send_byte(8'h78);
    idle(TMO - 1);
    vectors++;
    if (err_cnt != e0) begin
      miscompares++; $display("FAIL tmo_early: got %0d errs, want 0", err_cnt - e0);
    end
    send_byte(8'h56);  // arrives on the expiry cycle
    idle(TMO - 1);
    send_byte(8'h34); send_byte(8'h12);
    idle(3);
    vectors++;
    if (wq.size() != w0 + 1 || wq[w0] !== {8'h12, 32'h12345678} || err_cnt != e0) begin
      miscompares++; $display("FAIL tmo_edge: got %0d writes %0d errs, want 1 write 1212345678 0 errs", wq.size() - w0, err_cnt - e0);
    end
    w0 = wq.size(); e0 = err_cnt;
    send_byte(WR); send_byte(8'h12); send_byte(8'h78);
    idle(TMO + 2);
    vectors++;
    if (err_cnt != e0 + 1 || wq.size() != w0) begin
      miscompares++; $display("FAIL tmo_abort: got %0d errs %0d writes, want 1 0", err_cnt - e0, wq.size() - w0);
    end
    send_frame(WR, 8'h34, 32'h44332211, 0);
    idle(3);
    vectors++;
    if (wq.size() != w0 + 1 || wq[w0] !== {8'h34, 32'h44332211}) begin
      miscompares++; $display("FAIL tmo_recover: got %0d writes, want 1 of 3444332211", wq.size() - w0);
    end
  endtask

  task automatic test_bad_cmd_reset;
    int w0 = wq.size(), e0 = err_cnt, ts;
    logic [31:0] d;
    send_byte(8'h55);
    idle(2);
    vectors++;
    if (err_cnt != e0 + 1) begin
      miscompares++; $display("FAIL badcmd_err: got %0d, want 1", err_cnt - e0);
    end
    d = $urandom;
    send_frame(WR, 8'h5A, d, 1);
    idle(3);
    vectors++;
    if (wq.size() != w0 + 1 || wq[w0] !== {8'h5A, d}) begin
      miscompares++; $display("FAIL badcmd_next: got %0d writes, want 1 of 5a%h", wq.size() - w0, d);
    end
    w0 = wq.size(); e0 = err_cnt;
    send_byte(WR); send_byte(8'h12); send_byte(8'h56);
    i_reset = 1'b1; idle(1); i_reset = 1'b0;
    idle(TMO + 5);
    vectors++;
    if (wq.size() != w0 || err_cnt != e0) begin
      miscompares++; $display("FAIL reset_midframe: got %0d writes %0d errs, want 0 0", wq.size() - w0, err_cnt - e0);
    end
    d = $urandom;
    send_frame(WR, 8'h07, d, 0);
    idle(3);
    vectors++;
    if (wq.size() != w0 + 1 || wq[w0] !== {8'h07, d}) begin
      miscompares++; $display("FAIL reset_next: got %0d writes, want 1 of 07%h", wq.size() - w0, d);
    end
    ts = tq.size();
    send_frame(RD, 8'h12, $urandom, 0);
    for (int k = 0; k < 20 && tq.size() < ts + 1; k++) idle(1);
    i_reset = 1'b1; idle(1); i_reset = 1'b0;
    ts = tq.size();
    idle(8);
    vectors++;
    if (tq.size() != ts || o_tx_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_midresp: got %0d extra bytes tx_data %h, want 0 00", tq.size() - ts, o_tx_data);
    end
  endtask

  task automatic test_random;
    int w0 = wq.size(), r0 = rq.size(), t0 = tq.size(), e0 = err_cnt, fv0 = full_viol, xerr = 0;
    logic [39:0] ew[$];
    logic [7:0]  er[$];
    logic [7:0]  et[$];
    logic [7:0]  a, b;
    logic [31:0] d, m;
    for (int it = 0; it < 40; it++) begin
      a = 8'($urandom); d = $urandom;
      case ($urandom_range(0, 2))
        0: begin
          send_frame(WR, a, d, 3);
          ew.push_back({a, d});
          idle(2);
        end
        1: begin
          send_frame(RD, a, d, 3);
          er.push_back(a);
          m = rmem[a];
          for (int i = 0; i < 4; i++) et.push_back(m[8*i +: 8]);
          for (int k = 0; k < 12; k++) begin
            i_tx_full = ($urandom_range(0, 2) == 0);
            idle(1);
          end
          i_tx_full = 1'b0;
          idle(6);
        end
        default: begin
          do b = 8'($urandom); while (b == WR || b == RD);
          send_byte(b);
          xerr++;
          idle(2);
        end
      endcase
    end
    vectors++;
    if (wq.size() - w0 != ew.size() || rq.size() - r0 != er.size() || tq.size() - t0 != et.size()) begin
      miscompares++;
      $display("FAIL rand_counts: got w%0d r%0d t%0d, want w%0d r%0d t%0d",
               wq.size() - w0, rq.size() - r0, tq.size() - t0, ew.size(), er.size(), et.size());
    end else begin
      for (int i = 0; i < ew.size(); i++) begin
        vectors++;
        if (wq[w0 + i] !== ew[i]) begin
          miscompares++; $display("FAIL rand_write%0d: got %h, want %h", i, wq[w0 + i], ew[i]);
        end
      end
      for (int i = 0; i < er.size(); i++) begin
        vectors++;
        if (rq[r0 + i] !== er[i]) begin
          miscompares++; $display("FAIL rand_read%0d: got %h, want %h", i, rq[r0 + i], er[i]);
        end
      end
      for (int i = 0; i < et.size(); i++) begin
        vectors++;
        if (tq[t0 + i] !== et[i]) begin
          miscompares++; $display("FAIL rand_tx%0d: got %h, want %h", i, tq[t0 + i], et[i]);
        end
      end
    end
    vectors++;
    if (err_cnt - e0 != xerr || full_viol != fv0) begin
      miscompares++; $display("FAIL rand_err: got %0d errs %0d viol, want %0d 0", err_cnt - e0, full_viol - fv0, xerr);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rmem[i] = $urandom;
    rmem[8'h12] = 32'h12345678;
    test_reset;
    test_write;
    test_read;
    test_tx_full;
    test_timeout;
    test_bad_cmd_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
